flt2fix_seq: RTL and testbench

Sequencer for the float-to-fixed 8.8 conversion datapath. It detects the test-bench request on the falling edge of start and fetches each half-precision operand from byte-wide data memory. It then hands the operand to the converter core over a start/valid handshake, writes the 16-bit result back to memory and returns a one-cycle done pulse. The block sits between TopLevel's start/done interface, data_mem and the converter core, and handles a batch of NUM_OPS operands per request.

---
 rtl/flt2fix_pkg.sv | 22 ++
 rtl/flt2fix_edge.sv | 27 ++
 rtl/flt2fix_seq.sv | 184 ++++++++++++++++++
 tb/tb_flt2fix_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flt2fix_pkg.sv
// Shared definitions for the float-to-fixed 8.8 sequencer.
//   seq_state_t      : sequencer FSM states
//   TIMEOUT_FILL     : result written when the converter never answers
//   DEFAULT_*_BASE   : default operand/result base addresses in data memory
package flt2fix_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    LAUNCH,
    CONV,
    WR_LO,
    WR_HI,
    DONE
  } seq_state_t;

  localparam logic [15:0] TIMEOUT_FILL     = 16'h8000;
  localparam int          DEFAULT_SRC_BASE = 4;
  localparam int          DEFAULT_DST_BASE = 6;

endpackage

// File: rtl/flt2fix_edge.sv
// Falling-edge detector for the bench request line.
//   clk   : clock
//   reset : synchronous reset, active-low
//   start : raw request level
//   fall  : high for the cycle in which the registered start is 1 and the
//           current start is 0
module flt2fix_edge (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic fall
);

  logic start_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  // Gated by reset so no trigger is reported while reset is held low.
  assign fall = reset && start_q && !start;

endmodule

// File: rtl/flt2fix_seq.sv
// Sequencer for the float-to-fixed 8.8 datapath. On a falling edge of start
// it reads NUM_OPS half-precision operands from byte-wide data memory, hands
// each to the converter core, writes the 16-bit results back and pulses done.
//
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   start               : request; a job begins on its falling edge (IDLE only)
//   done                : one-cycle completion pulse
//   busy                : high from the first job cycle through the done cycle
//   err                 : 1 if any conversion in the batch timed out (valid with done)
//   mem_addr/rd/wr/wdata: data memory request side
//   mem_rdata           : data memory read data, valid the cycle after mem_rd
//   conv_start          : one-cycle launch pulse, conv_operand valid with it
//   conv_operand        : half-precision operand {hi, lo}
//   conv_result         : 8.8 result, taken when conv_valid is high in CONV
//   conv_valid          : converter completion
//
// Handshakes: mem_rd/mem_wr are single-cycle commands with mem_addr; read data
// returns one cycle later. conv_start launches one conversion; the first
// conv_valid seen while in CONV completes it, conv_valid at any other time is
// ignored.
module flt2fix_seq
  import flt2fix_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int SRC_BASE = DEFAULT_SRC_BASE,
  parameter int DST_BASE = DEFAULT_DST_BASE,
  parameter int NUM_OPS  = 1,
  parameter int TIMEOUT  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              conv_start,
  output logic [15:0]       conv_operand,
  input  logic [15:0]       conv_result,
  input  logic              conv_valid
);

  localparam int IDX_W = 7;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPS - 1);

  // Operand and result windows must not overlap, otherwise results would
  // overwrite operands that are still to be read.
  if ((SRC_BASE + 2 * NUM_OPS > DST_BASE) && (DST_BASE + 2 * NUM_OPS > SRC_BASE)) begin : g_overlap_chk
    $error("flt2fix_seq: source and destination windows overlap");
  end
  if (NUM_OPS < 1 || NUM_OPS > 64) begin : g_num_ops_chk
    $error("flt2fix_seq: NUM_OPS must be 1..64");
  end

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [TMR_W-1:0]  timer_q;
  logic [7:0]        lo_q, hi_q;
  logic [15:0]       result_q;
  logic              err_q;
  logic              trigger;
  logic              last_op;
  logic              timed_out;
  logic [ADDR_W-1:0] src_addr, dst_addr;

  flt2fix_edge u_edge (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .fall  (trigger)
  );

  assign last_op   = (idx_q == IDX_LAST);
  assign timed_out = (timer_q == TMR_LAST);
  // Address arithmetic is ADDR_W wide and wraps naturally.
  assign src_addr  = ADDR_W'(SRC_BASE) + (ADDR_W'(idx_q) << 1);
  assign dst_addr  = ADDR_W'(DST_BASE) + (ADDR_W'(idx_q) << 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      timer_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (trigger) begin
            idx_q <= '0;
            err_q <= 1'b0;
          end
        end
        RD_HI:  lo_q <= mem_rdata;
        LAUNCH: begin
          hi_q    <= mem_rdata;
          timer_q <= '0;
        end
        CONV: begin
          if (conv_valid) begin
            result_q <= conv_result;
          end else if (timed_out) begin
            result_q <= TIMEOUT_FILL;
            err_q    <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WR_HI: begin
          if (!last_op) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    done         = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    conv_start   = 1'b0;
    conv_operand = '0;
    unique case (state_q)
      IDLE: begin
        if (trigger) state_d = RD_LO;
      end
      RD_LO: begin
        mem_rd   = 1'b1;
        mem_addr = src_addr;
        state_d  = RD_HI;
      end
      RD_HI: begin
        mem_rd   = 1'b1;
        mem_addr = src_addr + ADDR_W'(1);
        state_d  = LAUNCH;
      end
      LAUNCH: begin
        // The high byte arrives this cycle, so the operand is assembled
        // straight from mem_rdata rather than from hi_q.
        conv_start   = 1'b1;
        conv_operand = {mem_rdata, lo_q};
        state_d      = CONV;
      end
      CONV: begin
        conv_operand = {hi_q, lo_q};
        if (conv_valid || timed_out) state_d = WR_LO;
      end
      WR_LO: begin
        mem_wr    = 1'b1;
        mem_addr  = dst_addr;
        mem_wdata = result_q[7:0];
        state_d   = WR_HI;
      end
      WR_HI: begin
        mem_wr    = 1'b1;
        mem_addr  = dst_addr + ADDR_W'(1);
        mem_wdata = result_q[15:8];
        state_d   = last_op ? DONE : RD_LO;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_flt2fix_seq.sv
// Bench for flt2fix_seq: two instances (default single-operand layout and a
// three-operand layout at 16/32), each with its own byte memory and
// converter model. Expected results come from a half -> 8.8 arithmetic model.
module tb_flt2fix_seq;

  localparam int NI  = 2;
  localparam int TMO = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start        [NI];
  logic        done         [NI];
  logic        busy         [NI];
  logic        err          [NI];
  logic [7:0]  mem_addr     [NI];
  logic        mem_rd       [NI];
  logic        mem_wr       [NI];
  logic [7:0]  mem_wdata    [NI];
  logic [7:0]  mem_rdata    [NI];
  logic        conv_start   [NI];
  logic [15:0] conv_operand [NI];
  logic [15:0] conv_result  [NI];
  logic        conv_valid   [NI];

  flt2fix_seq u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .done(done[0]), .busy(busy[0]),
    .err(err[0]), .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .conv_start(conv_start[0]),
    .conv_operand(conv_operand[0]), .conv_result(conv_result[0]), .conv_valid(conv_valid[0])
  );

  flt2fix_seq #(.SRC_BASE(16), .DST_BASE(32), .NUM_OPS(3), .TIMEOUT(TMO)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .done(done[1]), .busy(busy[1]),
    .err(err[1]), .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .conv_start(conv_start[1]),
    .conv_operand(conv_operand[1]), .conv_result(conv_result[1]), .conv_valid(conv_valid[1])
  );

  function automatic int src_of(int g);  return (g == 0) ? 4 : 16; endfunction
  function automatic int dst_of(int g);  return (g == 0) ? 6 : 32; endfunction
  function automatic int nops_of(int g); return (g == 0) ? 1 : 3;  endfunction

  // Half-precision to 8.8 two's complement, truncating toward zero and
  // saturating; infinities and NaNs saturate by sign.
  function automatic logic [15:0] q88(input logic [15:0] h);
    int e, mag;
    e = int'(h[14:10]);
    if (e == 31) mag = 40000;
    else if (e == 0) mag = 0;
    else begin
      mag = 1024 + int'(h[9:0]);
      if (e >= 17) mag = mag << (e - 17);
      else mag = mag >> (17 - e);
    end
    if (h[15]) begin
      if (mag > 32768) mag = 32768;
      return 16'(-mag);
    end
    if (mag > 32767) mag = 32767;
    return 16'(mag);
  endfunction

  // ---------------- memory + converter models ----------------
  logic [7:0]  mem [NI][256];
  logic [15:0] op_seen [NI][1024];
  logic [15:0] res [NI];
  int          cnt [NI];
  int          lat [NI];
  int          wr_cnt [NI], rd_cnt [NI], cs_cnt [NI], done_cnt [NI];
  int          done_cyc [NI];
  logic        err_at_done [NI], busy_at_done [NI];
  int          both_cnt;
  int          cyc;
  logic        poke_en [NI];
  logic [7:0]  poke_addr, poke_data;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < NI; g++) begin
      if (poke_en[g]) mem[g][poke_addr] <= poke_data;
      if (mem_wr[g]) begin
        mem[g][mem_addr[g]] <= mem_wdata[g];
        wr_cnt[g] <= wr_cnt[g] + 1;
      end
      if (mem_rd[g]) begin
        mem_rdata[g] <= mem[g][mem_addr[g]];
        rd_cnt[g] <= rd_cnt[g] + 1;
      end
      if (conv_start[g]) begin
        cnt[g] <= lat[g];
        res[g] <= q88(conv_operand[g]);
        op_seen[g][cs_cnt[g] % 1024] <= conv_operand[g];
        cs_cnt[g] <= cs_cnt[g] + 1;
      end else if (cnt[g] > 0) begin
        cnt[g] <= cnt[g] - 1;
      end
    end
  end

  // lat==0 models a converter that never answers.
  always_comb begin
    for (int g = 0; g < NI; g++) begin
      conv_valid[g]  = (cnt[g] == 1);
      conv_result[g] = res[g];
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (done[g]) begin
        done_cnt[g]     <= done_cnt[g] + 1;
        done_cyc[g]     <= cyc;
        err_at_done[g]  <= err[g];
        busy_at_done[g] <= busy[g];
      end
      if (mem_rd[g] && mem_wr[g]) both_cnt <= both_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] job_ops[64];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke(input int g, input int a, input logic [7:0] d);
    @(negedge clk);
    poke_en[g] = 1'b1;
    poke_addr  = 8'(a);
    poke_data  = d;
    @(negedge clk);
    poke_en[g] = 1'b0;
  endtask

  task automatic pulse_start(input int g, output int t0);
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    t0 = cyc + 1;
  endtask

  task automatic load_ops(input int g);
    for (int i = 0; i < nops_of(g); i++) begin
      poke(g, src_of(g) + 2 * i, job_ops[i][7:0]);
      poke(g, src_of(g) + 2 * i + 1, job_ops[i][15:8]);
    end
  endtask

  task automatic check_idle_outputs(input int g, input string tag);
    check_eq({tag, "_busy"}, busy[g], 0);
    check_eq({tag, "_done"}, done[g], 0);
    check_eq({tag, "_rd"}, mem_rd[g], 0);
    check_eq({tag, "_wr"}, mem_wr[g], 0);
    check_eq({tag, "_cstart"}, conv_start[g], 0);
    check_eq({tag, "_addr"}, mem_addr[g], 0);
    check_eq({tag, "_wdata"}, mem_wdata[g], 0);
    check_eq({tag, "_oper"}, conv_operand[g], 0);
  endtask

  task automatic run_job(input int g, input int l, input bit retrig);
    int n, t0, w0, r0, c0, d0, eff;
    n = nops_of(g);
    lat[g] = l;
    load_ops(g);
    for (int i = 0; i < n; i++) exp_q.push_back((l == 0) ? 16'h8000 : q88(job_ops[i]));
    w0 = wr_cnt[g]; r0 = rd_cnt[g]; c0 = cs_cnt[g]; d0 = done_cnt[g];
    pulse_start(g, t0);
    if (retrig) begin
      repeat (2) @(negedge clk);
      start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
    end
    for (int k = 0; k < 2000 && done_cnt[g] == d0; k++) @(negedge clk);
    check_eq("done_seen", done_cnt[g] != d0, 1);
    eff = (l == 0) ? TMO : l;
    check_eq("latency", done_cyc[g] - t0 + 1, 1 + n * (5 + eff));
    check_eq("err", err_at_done[g], l == 0);
    check_eq("busy_at_done", busy_at_done[g], 1);
    repeat (12) @(negedge clk);
    check_eq("done_count", done_cnt[g] - d0, 1);
    check_eq("wr_count", wr_cnt[g] - w0, 2 * n);
    check_eq("rd_count", rd_cnt[g] - r0, 2 * n);
    check_eq("cstart_count", cs_cnt[g] - c0, n);
    check_eq("idle_after", busy[g], 0);
    for (int i = 0; i < n; i++) begin
      check_eq("operand", op_seen[g][(c0 + i) % 1024], job_ops[i]);
      check_eq("result", {mem[g][dst_of(g) + 2 * i + 1], mem[g][dst_of(g) + 2 * i]}, exp_q.pop_front());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0, w0, d0;
    reset = 1'b0;
    both_cnt = 0;
    cyc = 0;
    poke_addr = '0;
    poke_data = '0;
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0; poke_en[g] = 1'b0; lat[g] = 1;
      cnt[g] = 0; res[g] = '0; mem_rdata[g] = '0;
      wr_cnt[g] = 0; rd_cnt[g] = 0; cs_cnt[g] = 0; done_cnt[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check_idle_outputs(g, "rst");
      check_eq("rst_err", err[g], 0);
    end
    reset = 1'b1;

    // 1.0 with a one-cycle converter
    job_ops[0] = 16'h3C00;
    run_job(0, 1, 1'b0);
    check_eq("one_lo", mem[0][6], 8'h00);
    check_eq("one_hi", mem[0][7], 8'h01);

    // -1.0 with a five-cycle converter
    job_ops[0] = 16'hBC00;
    run_job(0, 5, 1'b0);
    check_eq("mone", {mem[0][7], mem[0][6]}, 16'hFF00);

    // three-operand batch
    job_ops[0] = 16'h4000; job_ops[1] = 16'h3800; job_ops[2] = 16'h7C00;
    run_job(1, 1, 1'b0);

    // timeout, then a good request clears err
    job_ops[0] = 16'h3C00;
    run_job(0, 0, 1'b0);
    job_ops[0] = 16'h4200;
    run_job(0, 2, 1'b0);

    // second falling edge while busy is ignored
    job_ops[0] = 16'h3555;
    run_job(0, 1, 1'b1);
    job_ops[0] = 16'hC100; job_ops[1] = 16'h5000; job_ops[2] = 16'h0001;
    run_job(1, 3, 1'b1);

    // reset while in CONV
    lat[0] = 0;
    job_ops[0] = 16'h3C00;
    load_ops(0);
    pulse_start(0, t0);
    repeat (6) @(negedge clk);
    check_eq("in_conv_busy", busy[0], 1);
    w0 = wr_cnt[0]; d0 = done_cnt[0];
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs(0, "midrst");
    check_eq("midrst_err", err[0], 0);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("midrst_nowr", wr_cnt[0] - w0, 0);
    check_eq("midrst_nodone", done_cnt[0] - d0, 0);
    job_ops[0] = 16'h3E00;
    run_job(0, 1, 1'b0);

    // randomized jobs
    for (int j = 0; j < 14; j++) begin
      int g, l;
      g = $urandom_range(0, NI - 1);
      l = $urandom_range(0, 6);
      for (int i = 0; i < 3; i++) job_ops[i] = 16'($urandom_range(0, 65535));
      run_job(g, l, ($urandom_range(0, 3) == 0));
    end

    check_eq("rd_wr_exclusive", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
